divider_tap_scheduler: RTL

Synchronous controller that replaces the free-running ripple divider chain with a single-clock, enable-gated binary divider and lets one requester reconfigure the divide ratio through a valid/ready handshake. Ratio changes are deferred to the end of the current output period, so the divided output never produces a runt pulse. It sits between the top-level configuration path and any logic that consumes a divided clock or a periodic strobe.

---
 rtl/freq_div_pkg.sv | 18 +
 rtl/sync_div_counter.sv | 22 ++
 rtl/divider_tap_scheduler.sv | 103 ++++++++++
 3 files changed

// File: rtl/freq_div_pkg.sv
// Shared types and sizing for the enable-gated divider and its tap scheduler.
package freq_div_pkg;

    localparam int unsigned DIV_STAGES_DEF = 7;

    // Tap-select width; a single-stage divider still needs one select bit.
    function automatic int unsigned sel_width(input int unsigned stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

    localparam int unsigned SEL_W_DEF = sel_width(DIV_STAGES_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } sched_state_e;

endpackage

// File: rtl/sync_div_counter.sv
// Free-running binary divider counter with count enable and synchronous clear.
module sync_div_counter
    import freq_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_STAGES_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk_in) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/divider_tap_scheduler.sv
// Binary clock divider whose tap is reconfigured through a valid/ready handshake;
// a new tap takes effect only at the end of the current output period.
module divider_tap_scheduler
    import freq_div_pkg::*;
#(
    parameter  int unsigned DIV_STAGES = DIV_STAGES_DEF,
    parameter  int unsigned RESET_SEL  = 0,
    localparam int unsigned SEL_W      = sel_width(DIV_STAGES)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             cfg_done,
    output logic             div_out,
    output logic             tick,
    output logic [SEL_W-1:0] cur_sel
);

    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(DIV_STAGES);

    sched_state_e          state;
    logic [SEL_W-1:0]      pend_sel;
    logic [DIV_STAGES-1:0] cnt;
    logic [DIV_STAGES-1:0] cnt_inc;
    logic [DIV_STAGES-1:0] tap_mask;
    logic                  accept;
    logic                  sel_bad;
    logic                  do_switch;
    logic                  div_nxt;

    sync_div_counter #(
        .WIDTH (DIV_STAGES)
    ) u_counter (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (do_switch),
        .cnt    (cnt)
    );

    // Period-end detection, handshake decode and the next value of the div_out flop.
    always_comb begin
        tap_mask = '0;
        for (int i = 0; i < int'(DIV_STAGES); i++) begin
            tap_mask[i] = (i <= int'(cur_sel));
        end
        cnt_inc   = cnt + DIV_STAGES'(1);
        tick      = en && ((cnt & tap_mask) == tap_mask);
        accept    = (state == IDLE) && cfg_valid && cfg_ready;
        sel_bad   = {1'b0, cfg_sel} >= SEL_LIMIT;
        do_switch = (state == PEND) && tick;
        div_nxt   = div_out;
        if (do_switch) begin
            div_nxt = 1'b0;
        end else if (en) begin
            div_nxt = cnt_inc[cur_sel];
        end
    end

    // Scheduler FSM with registered handshake and status outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_sel   <= SEL_W'(RESET_SEL);
            pend_sel  <= '0;
            div_out   <= 1'b0;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            cfg_err  <= 1'b0;
            cfg_done <= 1'b0;
            div_out  <= div_nxt;
            unique case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (accept) begin
                        if (sel_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            pend_sel  <= cfg_sel;
                            state     <= PEND;
                            cfg_ready <= 1'b0;
                        end
                    end
                end
                PEND: begin
                    if (do_switch) begin
                        cur_sel   <= pend_sel;
                        state     <= IDLE;
                        cfg_done  <= 1'b1;
                        cfg_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
